// File: rtl/fp32_to_bf16_narrow.sv
// rtl/fp32_to_bf16_narrow.sv - two-stage streaming fp32 to bf16 narrowing converter
//
// Converts fp32 words {sign, exp[7:0], mant[22:0]} into bf16 words
// {sign, exp[7:0], mant[6:0]} at one word per cycle with valid/ready on both sides.
//
// Stage 1 classifies the input and keeps sign, exponent, upper mantissa,
// guard (bit 15) and sticky (OR of bits 14:0). Stage 2 rounds, packs and
// holds the result until the consumer takes it.
//
// Parameters:
//   RNE      - 1: round-to-nearest-even, 0: truncate toward zero
//   FTZ_SIGN - 1: flushed subnormals keep the input sign, 0: flush to +0
//
// Optional macro NARROW_STATUS_EN adds out_status {invalid, overflow,
// underflow, inexact}, registered per word alongside out_data.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - in_data is valid
//   in_ready   - converter accepts in_data this cycle
//   in_data    - fp32 operand
//   out_valid  - out_data is valid
//   out_ready  - consumer accepts out_data this cycle
//   out_data   - bf16 result
//   out_status - per-word flags (NARROW_STATUS_EN only)

module fp32_to_bf16_narrow #(
    parameter bit RNE      = 1'b1,
    parameter bit FTZ_SIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
`ifdef NARROW_STATUS_EN
    ,
    output logic [3:0]  out_status
`endif
);

    typedef enum logic [2:0] {
        CL_ZERO,
        CL_SUBN,
        CL_NORM,
        CL_INF,
        CL_NAN
    } class_e;

    // Handshake / advance control
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load;
    logic s2_load;

    // Stage 1 fields
    logic       s1_sign_q;
    logic [7:0] s1_exp_q;
    logic [6:0] s1_mant_q;
    logic       s1_guard_q;
    logic       s1_sticky_q;
    class_e     s1_class_q;
    class_e     in_class;

    // Stage 2 result
    logic [15:0] s2_data_q, s2_data_d;

    // Rounding path
    logic        round_up;
    logic [14:0] rounded;
    logic        rnd_ovf;

    // An empty or draining stage always accepts; no path from in_valid to out_valid.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    assign s1_valid_d = s1_load ? in_valid   : s1_valid_q;
    assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

    always_comb begin
        in_class = CL_NORM;
        if (in_data[30:23] == 8'hFF) begin
            in_class = (in_data[22:0] != 23'd0) ? CL_NAN : CL_INF;
        end else if (in_data[30:23] == 8'h00) begin
            in_class = (in_data[22:0] != 23'd0) ? CL_SUBN : CL_ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= 8'h00;
            s1_mant_q   <= 7'h00;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_class_q  <= CL_ZERO;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load && in_valid) begin
                s1_sign_q   <= in_data[31];
                s1_exp_q    <= in_data[30:23];
                s1_mant_q   <= in_data[22:16];
                s1_guard_q  <= in_data[15];
                s1_sticky_q <= |in_data[14:0];
                s1_class_q  <= in_class;
            end
        end
    end

    // Exponent and mantissa are incremented as one field so a mantissa
    // carry ripples into the exponent; reaching 255 means overflow to Inf.
    always_comb begin
        round_up = RNE && s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
        rounded  = {s1_exp_q, s1_mant_q} + {14'd0, round_up};
        rnd_ovf  = (rounded[14:7] == 8'hFF);
    end

    always_comb begin
        s2_data_d = 16'h0000;
        case (s1_class_q)
            CL_NAN:  s2_data_d = {s1_sign_q, 8'hFF, 7'b1000000};
            CL_INF:  s2_data_d = {s1_sign_q, 8'hFF, 7'h00};
            CL_SUBN: s2_data_d = {(FTZ_SIGN ? s1_sign_q : 1'b0), 15'h0000};
            CL_ZERO: s2_data_d = {s1_sign_q, 15'h0000};
            CL_NORM: s2_data_d = rnd_ovf ? {s1_sign_q, 8'hFF, 7'h00}
                                         : {s1_sign_q, rounded};
            default: s2_data_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= 16'h0000;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load && s1_valid_q) begin
                s2_data_q <= s2_data_d;
            end
        end
    end

`ifdef NARROW_STATUS_EN
    logic [3:0] s2_status_q, s2_status_d;

    // {invalid, overflow, underflow, inexact}
    always_comb begin
        s2_status_d = 4'h0;
        case (s1_class_q)
            CL_NAN:  s2_status_d = 4'b1000;
            CL_SUBN: s2_status_d = 4'b0011;
            CL_NORM: s2_status_d = {1'b0, rnd_ovf, 1'b0,
                                    (s1_guard_q || s1_sticky_q)};
            default: s2_status_d = 4'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_status_q <= 4'h0;
        end else if (s2_load && s1_valid_q) begin
            s2_status_q <= s2_status_d;
        end
    end

    assign out_status = s2_status_q;
`endif

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

endmodule

// File: tb/tb_fp32_to_bf16_narrow.sv
// tb/tb_fp32_to_bf16_narrow.sv - directed self-checking bench for fp32_to_bf16_narrow

module tb_fp32_to_bf16_narrow;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    logic        t_in_valid;
    logic        t_in_ready;
    logic [31:0] t_in_data;
    logic        t_out_valid;
    logic        t_out_ready;
    logic [15:0] t_out_data;

`ifdef NARROW_STATUS_EN
    logic [3:0]  out_status;
    logic [3:0]  t_out_status;
`endif

    int errors = 0;
    int checks = 0;

    fp32_to_bf16_narrow #(.RNE(1'b1), .FTZ_SIGN(1'b1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef NARROW_STATUS_EN
        ,
        .out_status(out_status)
`endif
    );

    fp32_to_bf16_narrow #(.RNE(1'b0), .FTZ_SIGN(1'b0)) u_trunc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (t_in_valid),
        .in_ready  (t_in_ready),
        .in_data   (t_in_data),
        .out_valid (t_out_valid),
        .out_ready (t_out_ready),
        .out_data  (t_out_data)
`ifdef NARROW_STATUS_EN
        ,
        .out_status(t_out_status)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors: input, expected bf16, expected status
    localparam logic [31:0] RND_IN  [4] = '{32'h3F800000, 32'h3F808000, 32'h3F818000, 32'h3F808001};
    localparam logic [15:0] RND_OUT [4] = '{16'h3F80, 16'h3F80, 16'h3F82, 16'h3F81};
    localparam logic [3:0]  RND_ST  [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001};

    localparam logic [31:0] CO_IN   [2] = '{32'h3FFF8000, 32'h7F7FFFFF};
    localparam logic [15:0] CO_OUT  [2] = '{16'h4000, 16'h7F80};
    localparam logic [3:0]  CO_ST   [2] = '{4'b0001, 4'b0101};

    localparam logic [31:0] SP_IN   [5] = '{32'h7F800001, 32'hFF800000, 32'h80000001, 32'h00000000, 32'h80000000};
    localparam logic [15:0] SP_OUT  [5] = '{16'h7FC0, 16'hFF80, 16'h8000, 16'h0000, 16'h8000};
    localparam logic [3:0]  SP_ST   [5] = '{4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b0000};

    // Truncating instance, flushed subnormals go to +0
    localparam logic [31:0] TR_IN   [3] = '{32'h7F7FFFFF, 32'h3F818000, 32'h80000001};
    localparam logic [15:0] TR_OUT  [3] = '{16'h7F7F, 16'h3F81, 16'h0000};
    localparam logic [3:0]  TR_ST   [3] = '{4'b0001, 4'b0001, 4'b0011};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one word into an empty pipeline and reports result and latency
    // (cycles from the accepting edge to out_valid; 10 means it never came).
    task automatic run_vector(input logic use_t, input logic [31:0] din,
                              output logic [15:0] dout, output logic [3:0] st,
                              output int lat);
        st = 4'h0;
        out_ready   = 1'b1;
        t_out_ready = 1'b1;
        if (use_t) begin
            t_in_data  = din;
            t_in_valid = 1'b1;
        end else begin
            in_data  = din;
            in_valid = 1'b1;
        end
        step();
        in_valid   = 1'b0;
        t_in_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            if (use_t ? t_out_valid : out_valid) break;
            step();
            lat++;
        end
        dout = use_t ? t_out_data : out_data;
`ifdef NARROW_STATUS_EN
        st = use_t ? t_out_status : out_status;
`endif
        step();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 32'h0;
        out_ready   = 1'b1;
        t_in_valid  = 1'b0;
        t_in_data   = 32'h0;
        t_out_ready = 1'b1;
        #3;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out_data: got %h expected 0000", out_data);
        end
`ifdef NARROW_STATUS_EN
        checks++;
        if (out_status !== 4'h0) begin
            errors++;
            $display("FAIL reset_out_status: got %b expected 0000", out_status);
        end
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] d;
        logic [3:0]  st;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_vector(1'b0, RND_IN[i], d, st, lat);
            checks++;
            if (d !== RND_OUT[i]) begin
                errors++;
                $display("FAIL rounding_data[%0d]: in %h got %h expected %h", i, RND_IN[i], d, RND_OUT[i]);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL rounding_latency[%0d]: got %0d expected 2", i, lat);
            end
`ifdef NARROW_STATUS_EN
            checks++;
            if (st !== RND_ST[i]) begin
                errors++;
                $display("FAIL rounding_status[%0d]: got %b expected %b", i, st, RND_ST[i]);
            end
`endif
        end
    endtask

    task automatic test_carry_overflow();
        logic [15:0] d;
        logic [3:0]  st;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            run_vector(1'b0, CO_IN[i], d, st, lat);
            checks++;
            if (d !== CO_OUT[i]) begin
                errors++;
                $display("FAIL carry_data[%0d]: in %h got %h expected %h", i, CO_IN[i], d, CO_OUT[i]);
            end
`ifdef NARROW_STATUS_EN
            checks++;
            if (st !== CO_ST[i]) begin
                errors++;
                $display("FAIL carry_status[%0d]: got %b expected %b", i, st, CO_ST[i]);
            end
`endif
        end
    endtask

    task automatic test_specials();
        logic [15:0] d;
        logic [3:0]  st;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_vector(1'b0, SP_IN[i], d, st, lat);
            checks++;
            if (d !== SP_OUT[i]) begin
                errors++;
                $display("FAIL special_data[%0d]: in %h got %h expected %h", i, SP_IN[i], d, SP_OUT[i]);
            end
`ifdef NARROW_STATUS_EN
            checks++;
            if (st !== SP_ST[i]) begin
                errors++;
                $display("FAIL special_status[%0d]: got %b expected %b", i, st, SP_ST[i]);
            end
`endif
        end
    endtask

    task automatic test_truncate();
        logic [15:0] d;
        logic [3:0]  st;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_vector(1'b1, TR_IN[i], d, st, lat);
            checks++;
            if (d !== TR_OUT[i]) begin
                errors++;
                $display("FAIL truncate_data[%0d]: in %h got %h expected %h", i, TR_IN[i], d, TR_OUT[i]);
            end
`ifdef NARROW_STATUS_EN
            checks++;
            if (st !== TR_ST[i]) begin
                errors++;
                $display("FAIL truncate_status[%0d]: got %b expected %b", i, st, TR_ST[i]);
            end
`endif
        end
    endtask

    // Words 3F80_0000 + (i << 16) narrow exactly to 3F80 + i.
    task automatic test_backpressure();
        int          sent = 0;
        int          got = 0;
        logic        saw_stall = 1'b0;
        logic        prev_stalled = 1'b0;
        logic [15:0] prev_data = 16'h0;
        logic        acc;
        for (int c = 0; c < 40 && got < 8; c++) begin
            in_valid  = (sent < 8);
            in_data   = 32'h3F800000 | (32'(sent) << 16);
            out_ready = !(c >= 3 && c <= 6);
            #1;
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (prev_stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d got valid %b data %h expected valid 1 data %h",
                             c, out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== 16'h3F80 + 16'(got)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h expected %h", got, out_data, 16'h3F80 + 16'(got));
                end
                got++;
            end
            prev_stalled = out_valid && !out_ready;
            prev_data    = out_data;
            acc          = in_valid && in_ready;
            step();
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 8) begin
            errors++;
            $display("FAIL bp_count: got %0d words expected 8", got);
        end
        checks++;
        if (saw_stall !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready_drop: saw stall %b expected 1", saw_stall);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_extra_output: got data %h expected no output", out_data);
            end
            step();
        end
    endtask

    // Words 3F80_8000 + (i << 16) are exact ties: odd i rounds up, even stays.
    task automatic test_back_to_back();
        int   sent = 0;
        int   got = 0;
        int   cyc [16];
        logic acc;
        logic [15:0] exp_d;
        for (int c = 0; c < 60 && got < 16; c++) begin
            in_valid  = (sent < 16);
            in_data   = 32'h3F808000 | (32'(sent) << 16);
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                exp_d = 16'h3F80 + 16'(got) + 16'(got & 1);
                checks++;
                if (out_data !== exp_d) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", got, out_data, exp_d);
                end
                cyc[got] = c;
                got++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 16) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 16", got);
        end else begin
            checks++;
            if (cyc[0] !== 2) begin
                errors++;
                $display("FAIL b2b_first_latency: got %0d expected 2", cyc[0]);
            end
            checks++;
            if (cyc[15] - cyc[0] !== 15) begin
                errors++;
                $display("FAIL b2b_consecutive: span %0d expected 15", cyc[15] - cyc[0]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] d;
        logic [3:0]  st;
        int          lat;
        logic        stale = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        step();
        in_data   = 32'h40000000;
        step();
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_full: got valid %b in_ready %b expected valid 1 in_ready 0", out_valid, in_ready);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid_drop: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_data_clear: got %h expected 0000", out_data);
        end
`ifdef NARROW_STATUS_EN
        checks++;
        if (out_status !== 4'h0) begin
            errors++;
            $display("FAIL midrst_status_clear: got %b expected 0000", out_status);
        end
`endif
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (out_valid) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale: stale output seen %b expected 0", stale);
        end
        run_vector(1'b0, 32'h3F818000, d, st, lat);
        checks++;
        if (d !== 16'h3F82) begin
            errors++;
            $display("FAIL midrst_new_data: got %h expected 3F82", d);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL midrst_new_latency: got %0d expected 2", lat);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_carry_overflow();
        test_specials();
        test_truncate();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
